sipo_frame_ctrl: RTL
====================

// Module: sipo_frame_ctrl
// PURPOSE
//   Frame controller for a serial-in parallel-out capture path. Starts a frame on a start
//   pulse and counts WIDTH sampled bits into an internal shift register. It then moves the
//   finished word into a one-entry output buffer, emptied through a valid/ready handshake.
//   Sits between a serial front end (bit strobe) and any parallel consumer; flags overruns.
// PARAMETERS
//   WIDTH      10  bits per frame / parallel word width (>= 2)
//   CNT_W       4  bit-counter width; must satisfy 2**CNT_W > WIDTH
//   LSB_FIRST   1  1: first bit lands in word[0] (right shift, new bit enters MSB);
//                  0: first bit lands in word[WIDTH-1] (left shift, new bit enters LSB)
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous, active-low reset
//   en          in   1      capture enable; low aborts any frame in progress
//   start       in   1      frame start pulse (one cycle)
//   sample_en   in   1      bit strobe: sdata is valid this cycle
//   sdata       in   1      serial data bit
//   clr_ovr     in   1      synchronous clear of the overrun flag
//   word_out    out  WIDTH  captured word; stable while word_valid=1
//   word_valid  out  1      output buffer holds an unconsumed word
//   word_ready  in   1      consumer accepts word_out when word_valid & word_ready
//   busy        out  1      1 while in SHIFT state
//   bit_cnt     out  CNT_W  bits captured in the current frame (0..WIDTH-1)
//   overrun     out  1      sticky: a completed frame was dropped (buffer full)
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE; shreg, word_out, bit_cnt = 0; word_valid, busy, overrun = 0.
//   FSM states: IDLE, SHIFT.
//   IDLE: en & start -> SHIFT, bit_cnt<=0, shreg<=0. A sample_en in the start cycle is ignored.
//   SHIFT, each cycle:
//     en=0 -> IDLE; partial frame discarded; bit_cnt<=0. word_out/word_valid untouched.
//     else start=1 -> restart: bit_cnt<=0, shreg<=0, stay SHIFT; sample_en ignored this cycle.
//     else sample_en=1 -> shift sdata in per LSB_FIRST; bit_cnt<=bit_cnt+1.
//       If bit_cnt==WIDTH-1, the frame completes: the assembled word (incl. this bit)
//       goes to the buffer, bit_cnt<=0, state -> IDLE.
//     else -> hold.
//   Buffer load at frame completion (all decided in the completing cycle):
//     buffer empty, or consumed this cycle (word_valid & word_ready): word_out<=word,
//       word_valid<=1 next cycle. Back-to-back consume+load keeps word_valid high, no overrun.
//     buffer full and not consumed: new word dropped, word_out unchanged, overrun<=1.
//   Latency: word_valid rises on the edge that samples the WIDTH-th bit (visible next cycle).
//   Handshake: word_valid falls after any edge with word_valid & word_ready and no
//     simultaneous load. word_ready while word_valid=0 has no effect.
//   overrun: set as above; cleared by clr_ovr. A set in the same cycle as clr_ovr wins.
//   busy = (state==SHIFT). bit_cnt never exceeds WIDTH-1 and wraps to 0 only via
//     completion, restart or abort.
//   Reset mid-frame or with word_valid=1: all state lost immediately. No output produced.
// TESTING  (bench uses WIDTH=4, LSB_FIRST=1 unless stated)
//   1 reset: rst=0 mid-run -> word_out=0, word_valid=0, busy=0, overrun=0 before next clk edge.
//   2 frame: start, then sdata 1,0,1,1 with sample_en every cycle -> word_out=4'b1101,
//     word_valid=1 one cycle after 4th bit; word_ready=1 -> word_valid=0 next cycle.
//   3 LSB_FIRST=0, same bits -> word_out=4'b1011. Gapped sample_en (every 3rd cycle)
//     -> same result; bit_cnt steps 0,1,2,3 only on strobes.
//   4 overrun: two frames 1101 then 0110, word_ready=0 -> word_out stays 1101, overrun=1.
//     clr_ovr -> overrun=0.
//   5 abort/restart: en=0 after 2 bits -> IDLE, bit_cnt=0, no word. Restart: start after 2
//     bits, then 0,0,1,1 -> word_out=4'b1100.
//   6 consume+load same cycle: word_ready=1 on 2nd frame completion edge -> word_valid
//     stays 1, word_out = 2nd word, overrun=0.

Source files
------------

// File: rtl/sipo_frame_ctrl.sv
// Serial-in parallel-out frame controller: assembles WIDTH strobed bits into a word
// and hands it off through a one-entry valid/ready buffer with sticky overrun flag.
module sipo_frame_ctrl #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned CNT_W     = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             sample_en,
  input  logic             sdata,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] word_asm_c;
  logic             frame_done_c;
  logic             consume_c;
  logic             set_ovr_c;

  // Shift direction decides which end of the word the first bit ends up in.
  always_comb begin
    if (LSB_FIRST) begin
      word_asm_c = {sdata, shreg_q[WIDTH-1:1]};
    end else begin
      word_asm_c = {shreg_q[WIDTH-2:0], sdata};
    end
  end

  // Next-state, capture and output-buffer logic.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    valid_d      = valid_q;
    ovr_d        = ovr_q;
    frame_done_c = 1'b0;
    set_ovr_c    = 1'b0;
    consume_c    = valid_q & word_ready;

    case (state_q)
      IDLE: begin
        if (en && start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      SHIFT: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
          shreg_d = '0;
        end else if (start) begin
          cnt_d   = '0;
          shreg_d = '0;
        end else if (sample_en) begin
          shreg_d = word_asm_c;
          if (cnt_q == LAST_CNT) begin
            frame_done_c = 1'b1;
            cnt_d        = '0;
            state_d      = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A consume and a load in the same cycle keeps the buffer occupied.
    if (consume_c) begin
      valid_d = 1'b0;
    end
    if (frame_done_c) begin
      if (!valid_q || consume_c) begin
        word_d  = word_asm_c;
        valid_d = 1'b1;
      end else begin
        set_ovr_c = 1'b1;
      end
    end

    // A new overrun outranks a clear in the same cycle.
    if (clr_ovr) begin
      ovr_d = 1'b0;
    end
    if (set_ovr_c) begin
      ovr_d = 1'b1;
    end

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign busy       = busy_q;
  assign bit_cnt    = cnt_q;
  assign overrun    = ovr_q;

endmodule
